mux_stim_ctrl: RTL

- Upstream stimulus/control stage for the 2-to-1 mux (`in1`/`in2` 2-bit data, `sel` 1-bit).
- Debounces a board push-button. Each confirmed press toggles `sel`.
- Generates two slow-stepping 2-bit data patterns, so the mux output is visible on LEDs when the design runs on the board.

---
 rtl/mux_stim_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/mux_stim_ctrl.sv
// Stimulus/control stage for the 2:1 LED mux demo.
// Debounced push-button toggles sel; a slow divider steps in1/in2.
module mux_stim_ctrl #(
  parameter logic [19:0] CNT_MAX = 20'd999_999,
  parameter logic [23:0] DIV_MAX = 24'd12_499_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_in,
  output logic [1:0] in1,
  output logic [1:0] in2,
  output logic       sel,
  output logic       key_flag
);

  typedef enum logic [1:0] {
    IDLE,
    FILT_DN,
    DOWN,
    FILT_UP
  } state_t;

  // cnt reaching CNT_MAX-1 on this edge completes the filter window
  localparam logic [19:0] CNT_LAST = CNT_MAX - 20'd2;

  state_t      state_q;
  logic [19:0] cnt_q;
  logic        sync1_q;
  logic        sync2_q;
  logic        sel_q;
  logic        key_flag_q;
  logic [23:0] div_q;
  logic [1:0]  in1_q;
  logic [1:0]  in2_q;
  logic        key_sync;

  assign key_sync = sync2_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      sel_q      <= 1'b0;
      key_flag_q <= 1'b0;
    end else begin
      sync1_q    <= key_in;
      sync2_q    <= sync1_q;
      key_flag_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!key_sync) begin
            state_q <= FILT_DN;
            cnt_q   <= '0;
          end
        end
        FILT_DN: begin
          if (key_sync) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q    <= DOWN;
            cnt_q      <= '0;
            key_flag_q <= 1'b1;
            sel_q      <= ~sel_q;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end
        DOWN: begin
          if (key_sync) begin
            state_q <= FILT_UP;
            cnt_q   <= '0;
          end
        end
        FILT_UP: begin
          if (!key_sync) begin
            state_q <= DOWN;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_q <= '0;
      in1_q <= 2'b00;
      in2_q <= 2'b11;
    end else if (div_q == DIV_MAX) begin
      div_q <= '0;
      in1_q <= in1_q + 2'd1;
      in2_q <= in2_q - 2'd1;
    end else begin
      div_q <= div_q + 24'd1;
    end
  end

  assign in1      = in1_q;
  assign in2      = in2_q;
  assign sel      = sel_q;
  assign key_flag = key_flag_q;

endmodule
